// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock sequencer: FSM state encoding,
// BCD HH:MM packing and second-counter widths.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01,
        SNOOZE = 2'b10
    } alarm_state_t;

    // BCD time word {h_tens, h_units, m_tens, m_units}
    localparam int TIME_W       = 16;
    localparam int BCD_W        = 4;
    localparam int H_TENS_OFS   = 12;
    localparam int H_UNITS_OFS  = 8;
    localparam int M_TENS_OFS   = 4;
    localparam int M_UNITS_OFS  = 0;

    localparam int SEC_CNT_W    = 10;
    localparam int SNOOZE_CNT_W = 2;

    // Compare one BCD digit of two packed time words
    function automatic logic bcd_digit_eq(input logic [TIME_W-1:0] a,
                                          input logic [TIME_W-1:0] b,
                                          input int              ofs);
        return a[ofs +: BCD_W] == b[ofs +: BCD_W];
    endfunction

    // Full HH:MM equality, digit by digit
    function automatic logic hhmm_eq(input logic [TIME_W-1:0] a,
                                     input logic [TIME_W-1:0] b);
        return bcd_digit_eq(a, b, H_TENS_OFS)  && bcd_digit_eq(a, b, H_UNITS_OFS) &&
               bcd_digit_eq(a, b, M_TENS_OFS)  && bcd_digit_eq(a, b, M_UNITS_OFS);
    endfunction

endpackage

// File: rtl/alarm_time_match.sv
// Time comparator with rising-edge detect: o_trigger pulses on the first clk
// in which the two time words become equal while i_enable is high. The
// previous-match register resets to 1 so a match already present at reset
// release is not treated as a new edge. Reusable for hourly chime logic.
module alarm_time_match
    import alarm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [TIME_W-1:0] i_current_time,
    input  logic [TIME_W-1:0] i_alarm_time,
    output logic              o_trigger
);

    logic w_match;
    logic r_match_d;

    assign w_match = hhmm_eq(i_current_time, i_alarm_time);

    // Remember last clk's match so only the leading edge of a match fires
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_match_d <= 1'b1;
        else         r_match_d <= w_match;
    end

    assign o_trigger = w_match & ~r_match_d & i_enable;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: rings on the first clk of the matching minute, times out
// after RING_SECS ticks, supports snooze with re-ring after SNOOZE_SECS ticks.
// Optional build macro ALARM_SNOOZE_LIMIT_EN: when defined, snooze in RING is
// honoured only while snooze_cnt < MAX_SNOOZE; otherwise snooze is unlimited.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1s,
    input  logic              alarm_on,
    input  logic [TIME_W-1:0] current_time,
    input  logic [TIME_W-1:0] alarm_time,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              sound_alarm,
    output logic              snoozing,
    output logic [1:0]        snooze_cnt
);

    localparam logic [SEC_CNT_W-1:0] RING_LAST   = SEC_CNT_W'(RING_SECS - 1);
    localparam logic [SEC_CNT_W-1:0] SNOOZE_LAST = SEC_CNT_W'(SNOOZE_SECS - 1);

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam bit SNOOZE_LIMITED = 1'b1;
`else
    localparam bit SNOOZE_LIMITED = 1'b0;
`endif

    alarm_state_t            r_state, w_state_nxt;
    logic [SEC_CNT_W-1:0]    r_sec_cnt, w_sec_cnt_nxt;
    logic [SNOOZE_CNT_W-1:0] r_snooze_cnt, w_snooze_cnt_nxt;
    logic                    r_sound_alarm, r_snoozing;
    logic                    w_trigger;
    logic                    w_snooze_ok;

    // Snooze counter increments but sticks at its maximum value
    function automatic logic [SNOOZE_CNT_W-1:0] sat_inc(input logic [SNOOZE_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    alarm_time_match u_match (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (alarm_on),
        .i_current_time (current_time),
        .i_alarm_time   (alarm_time),
        .o_trigger      (w_trigger)
    );

    assign w_snooze_ok = !SNOOZE_LIMITED || (int'(r_snooze_cnt) < MAX_SNOOZE);

    // Next state and counters; priority: alarm_on low > stop > snooze > tick expiry
    always_comb begin
        w_state_nxt      = r_state;
        w_sec_cnt_nxt    = r_sec_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_nxt      = RING;
                    w_sec_cnt_nxt    = '0;
                    w_snooze_cnt_nxt = '0;
                end
            end
            RING: begin
                if (!alarm_on || stop_btn) begin
                    w_state_nxt = IDLE;
                end else if (snooze_btn && w_snooze_ok) begin
                    w_state_nxt      = SNOOZE;
                    w_sec_cnt_nxt    = '0;
                    w_snooze_cnt_nxt = sat_inc(r_snooze_cnt);
                end else if (tick_1s) begin
                    if (r_sec_cnt == RING_LAST) w_state_nxt = IDLE;
                    else                        w_sec_cnt_nxt = r_sec_cnt + 1'b1;
                end
            end
            SNOOZE: begin
                if (!alarm_on || stop_btn) begin
                    w_state_nxt = IDLE;
                end else if (tick_1s) begin
                    if (r_sec_cnt == SNOOZE_LAST) begin
                        w_state_nxt   = RING;
                        w_sec_cnt_nxt = '0;
                    end else begin
                        w_sec_cnt_nxt = r_sec_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset silences the alarm at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sec_cnt     <= '0;
            r_snooze_cnt  <= '0;
            r_sound_alarm <= 1'b0;
            r_snoozing    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sec_cnt     <= w_sec_cnt_nxt;
            r_snooze_cnt  <= w_snooze_cnt_nxt;
            r_sound_alarm <= (w_state_nxt == RING);
            r_snoozing    <= (w_state_nxt == SNOOZE);
        end
    end

    assign sound_alarm = r_sound_alarm;
    assign snoozing    = r_snoozing;
    assign snooze_cnt  = r_snooze_cnt;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Testbench for alarm_sequencer: directed table, multi-cycle corner cases
// and a randomized run against a seconds-remaining reference model.
module tb_alarm_sequencer;

    localparam int RING_S   = 60;
    localparam int SNOOZE_S = 300;
    localparam int MAX_SNZ  = 3;
`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif
    localparam logic [15:0] ALM = 16'h0730;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1s = 1'b0;
    logic        alarm_on = 1'b0;
    logic [15:0] current_time = 16'h0000;
    logic [15:0] alarm_time = ALM;
    logic        snooze_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic        sound_alarm;
    logic        snoozing;
    logic [1:0]  snooze_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: ringing/snoozing flags plus seconds left in the phase
    bit m_ring, m_snz, m_prev;
    int m_left, m_cnt;

    alarm_sequencer #(.RING_SECS(RING_S), .SNOOZE_SECS(SNOOZE_S), .MAX_SNOOZE(MAX_SNZ)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1s      (tick_1s),
        .alarm_on     (alarm_on),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .snooze_btn   (snooze_btn),
        .stop_btn     (stop_btn),
        .sound_alarm  (sound_alarm),
        .snoozing     (snoozing),
        .snooze_cnt   (snooze_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tick, on, snz, stop;
        logic [15:0] cur;
        logic        e_sound, e_snz;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic mdl_reset();
        m_ring = 0; m_snz = 0; m_cnt = 0; m_left = 0; m_prev = 1;
    endtask

    task automatic mdl_step();
        bit match, trig;
        match  = (current_time == alarm_time);
        trig   = match && !m_prev && alarm_on;
        m_prev = match;
        if (m_ring) begin
            if (!alarm_on || stop_btn) m_ring = 0;
            else if (snooze_btn && (!LIM || m_cnt < MAX_SNZ)) begin
                m_ring = 0; m_snz = 1; m_left = SNOOZE_S;
                m_cnt = (m_cnt >= 3) ? 3 : m_cnt + 1;
            end else if (tick_1s) begin
                m_left--;
                if (m_left == 0) m_ring = 0;
            end
        end else if (m_snz) begin
            if (!alarm_on || stop_btn) m_snz = 0;
            else if (tick_1s) begin
                m_left--;
                if (m_left == 0) begin m_snz = 0; m_ring = 1; m_left = RING_S; end
            end
        end else if (trig) begin
            m_ring = 1; m_left = RING_S; m_cnt = 0;
        end
    endtask

    // called at a negedge: drive inputs, let one posedge pass, return at negedge
    task automatic cyc(input logic t, input logic on, input logic s, input logic p,
                       input logic [15:0] cur);
        tick_1s = t; alarm_on = on; snooze_btn = s; stop_btn = p; current_time = cur;
        @(posedge clk);
        mdl_step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic es, input logic ez, input logic [1:0] ec);
        n_vec++;
        if (sound_alarm !== es || snoozing !== ez || snooze_cnt !== ec) begin
            n_bad++;
            $display("FAIL %s: sound/snoozing/cnt = %b/%b/%0d, expected %b/%b/%0d",
                     nm, sound_alarm, snoozing, snooze_cnt, es, ez, ec);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, current_time);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, current_time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick_1s = 0; snooze_btn = 0; stop_btn = 0; alarm_on = 1; current_time = 16'h0729;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mdl_reset();
    endtask

    task automatic arm_and_ring();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0729);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, ALM);
    endtask

    initial begin
        logic [15:0] rc;
        logic        ron;

        //           tick on  snz stop cur       sound snz cnt
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0729, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0730, 1'b1, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0730, 1'b1, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0730, 1'b0, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0730, 1'b0, 1'b1, 2'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0730, 1'b0, 1'b0, 2'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0730, 1'b0, 1'b0, 2'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0730, 1'b0, 1'b0, 2'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0731, 1'b0, 1'b0, 2'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0730, 1'b1, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0730, 1'b0, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0731, 1'b0, 1'b0, 2'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0730, 1'b0, 1'b0, 2'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0730, 1'b0, 1'b0, 2'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0731, 1'b0, 1'b0, 2'd0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0730, 1'b1, 1'b0, 2'd0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0730, 1'b0, 1'b0, 2'd0};

        mdl_reset();
        repeat (2) @(negedge clk);
        chk("reset_held", 1'b0, 1'b0, 2'd0);

        // directed table
        do_reset();
        chk("reset_release", 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].tick, tbl[i].on, tbl[i].snz, tbl[i].stop, tbl[i].cur);
            chk($sformatf("table[%0d]", i), tbl[i].e_sound, tbl[i].e_snz, tbl[i].e_cnt);
        end

        // ring timeout after exactly RING_S ticks
        do_reset();
        arm_and_ring();
        chk("trigger_rise", 1'b1, 1'b0, 2'd0);
        ticks(RING_S - 1);
        chk("ring_before_timeout", 1'b1, 1'b0, 2'd0);
        ticks(1);
        chk("ring_timeout", 1'b0, 1'b0, 2'd0);

        // snooze cycle and re-ring
        do_reset();
        arm_and_ring();
        ticks(5);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, ALM);
        chk("snooze_enter", 1'b0, 1'b1, 2'd1);
        ticks(SNOOZE_S - 1);
        chk("snooze_before_rering", 1'b0, 1'b1, 2'd1);
        ticks(1);
        chk("snooze_rering", 1'b1, 1'b0, 2'd1);

        // snooze limit / saturation
        cyc(1'b0, 1'b1, 1'b1, 1'b0, ALM);
        chk("snooze2", 1'b0, 1'b1, 2'd2);
        ticks(SNOOZE_S);
        chk("rering2", 1'b1, 1'b0, 2'd2);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, ALM);
        chk("snooze3", 1'b0, 1'b1, 2'd3);
        ticks(SNOOZE_S);
        chk("rering3", 1'b1, 1'b0, 2'd3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, ALM);
        if (LIM) chk("snooze4_limited", 1'b1, 1'b0, 2'd3);
        else     chk("snooze4_saturate", 1'b0, 1'b1, 2'd3);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, ALM);
        chk("stop_after_snooze4", 1'b0, 1'b0, 2'd3);

        // asynchronous reset mid-ring, no re-ring while time still matches
        do_reset();
        arm_and_ring();
        chk("ring_before_async_reset", 1'b1, 1'b0, 2'd0);
        #2 reset = 1'b1;
        #1 chk("async_reset_drop", 1'b0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mdl_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(i[0], 1'b1, 1'b0, 1'b0, ALM);
            chk("no_ring_after_reset", 1'b0, 1'b0, 2'd0);
        end

        // randomized run against the reference model
        do_reset();
        rc  = 16'h0729;
        ron = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: rc = 16'h0729;
                    1: rc = 16'h0731;
                    default: rc = ALM;
                endcase
            end
            if ($urandom_range(0, 299) == 0) ron = ~ron;
            cyc(1'($urandom_range(0, 1)), ron, ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 399) == 0), rc);
            chk("random", m_ring, m_snz, 2'(m_cnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
